div_unit: RTL and testbench
===========================

// Module: div_unit
// PURPOSE
//  Iterative radix-2 restoring divider for DIV/DIVU, downstream of instruction decode in EX.
//  Decode's div/mdsign qualify a start; operands are GPR[rs]/GPR[rt].
//  Quotient -> LO, remainder -> HI, written by the HI/LO write path on done.
//  EX stalls the pipe while busy.
// PARAMETERS
//  DW     32  operand/result width
//  CNT_W  6   iteration counter width (must hold DW)
// PORTS
//  clk     in   1   single clock, rising edge
//  resetn  in   1   asynchronous, active-low reset
//  start   in   1   decoded div op valid in EX
//  mdsign  in   1   1: signed (DIV), 0: unsigned (DIVU); sampled with start
//  a       in   DW  dividend (GPR[rs])
//  b       in   DW  divisor (GPR[rt])
//  flush   in   1   exception/eret cancel; kills an in-flight divide
//  busy    out  1   1: divide in progress, stall EX
//  done    out  1   one-cycle pulse; hi/lo valid
//  hi      out  DW  remainder, held until next done
//  lo      out  DW  quotient, held until next done
// BEHAVIOUR
//  Reset (resetn=0, async, any state): state=IDLE, busy=0, done=0, hi=0, lo=0, cnt=0.
//  States: IDLE, RUN. done is a registered pulse, not a state.
//  IDLE & start & !flush at edge E0:
//   - latch |a|, |b| (two's-complement abs when mdsign, else raw)
//   - latch sign_q = mdsign & (a[DW-1]^b[DW-1]) and sign_r = mdsign & a[DW-1]
//   - clear remainder/quotient/cnt; go RUN; busy=1 from E0
//  RUN, each edge:
//   - rem' = {rem, dividend msb}; if rem' >= |b| then subtract and set q bit=1, else 0
//   - shift dividend left; cnt++
//  32nd RUN edge (E32):
//   - lo <= sign_q ? -q : q; hi <= sign_r ? -rem : rem
//   - done <= 1 for exactly one cycle; busy <= 0; state <= IDLE
//  Latency: start sampled E0 -> done/hi/lo visible in the cycle after E32 (32 cycles).
//  start while RUN: ignored.
//  start in the done cycle: accepted (back-to-back issue).
//  Unsigned |x| uses DW bits only: 0x8000_0000 abs = 0x8000_0000, so no overflow path.
//   Signed 0x8000_0000 / -1 -> lo=0x8000_0000, hi=0.
//  Divide by zero (b==0): result forced regardless of mdsign: lo=0xFFFF_FFFF, hi=a (raw).
//  flush (highest priority, synchronous):
//   - next edge: state=IDLE, busy=0, done=0, cnt=0; hi/lo keep prior values
//   - flush & start in the same cycle: start dropped
//  done and flush never both high: flush in the E32 cycle suppresses the done write.
// CONFIGURATION
//  DIV_ZERO_FAST_EN defined:
//   - start with b==0 writes lo=0xFFFF_FFFF, hi=a at E0
//   - done pulses in the cycle after E0; busy never rises; RUN skipped
//  Undefined: b==0 takes the full 32-cycle RUN, same final values.
// TESTING
//  1. DIVU a=100 b=7 -> lo=14 hi=2; done exactly 32 cycles after start edge; busy high 32 cycles.
//  2. DIV a=-7(0xFFFFFFF9) b=2 -> lo=0xFFFFFFFD hi=0xFFFFFFFF; DIVU same operands
//     -> lo=0x7FFFFFFC hi=1.
//  3. DIV a=0x80000000 b=0xFFFFFFFF -> lo=0x80000000 hi=0; then start in done cycle
//     a=9 b=3 -> lo=3 hi=0 after 32 more cycles.
//  4. DIVU a=50 b=5 done (lo=10,hi=0); start a=1 b=1, flush at RUN cycle 10
//     -> busy=0 next cycle, no done, lo=10 hi=0 held.
//  5. DIV a=5 b=0 -> lo=0xFFFFFFFF hi=5; done after 32 cycles
//     (after 1 cycle, busy never high, with DIV_ZERO_FAST_EN).
//  6. resetn low asynchronously at RUN cycle 5 -> busy=0 done=0 hi=0 lo=0 immediately;
//     release, start a=8 b=3 -> lo=2 hi=2.

Source files
------------

// File: rtl/div_unit.sv
// div_unit: iterative radix-2 restoring divider for DIV/DIVU in the EX stage.
// The dividend and divisor are reduced to magnitudes at issue. One quotient bit
// is produced per clock over DW clocks. Signs are then re-applied to the results.
// The quotient goes to lo and the remainder to hi.
// Optional feature macro: DIV_ZERO_FAST_EN. When it is defined, a divide by zero
// completes in the cycle after issue and the RUN state is skipped.
module div_unit #(
    parameter int DW    = 32,
    parameter int CNT_W = 6
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic          mdsign,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic          flush,
    output logic          busy,
    output logic          done,
    output logic [DW-1:0] hi,
    output logic [DW-1:0] lo
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    // Two's-complement negation within DW bits.
    function automatic logic [DW-1:0] neg2c(input logic [DW-1:0] x);
        return (~x) + {{(DW-1){1'b0}}, 1'b1};
    endfunction

    // Magnitude of x. The negation is only applied for signed operands.
    // The most negative value maps onto itself, which is still correct as unsigned.
    function automatic logic [DW-1:0] abs2c(input logic [DW-1:0] x, input logic en);
        return (en && x[DW-1]) ? neg2c(x) : x;
    endfunction

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    dvd_q, dvd_d;       // dividend magnitude, shifted out msb first
    logic [DW-1:0]    dvs_q, dvs_d;       // divisor magnitude
    logic [DW-1:0]    rem_q, rem_d;       // partial remainder
    logic [DW-1:0]    quo_q, quo_d;       // partial quotient
    logic             neg_quo_q, neg_quo_d;
    logic             neg_rem_q, neg_rem_d;
    logic             bzero_q, bzero_d;   // divisor was zero: quotient forced to all ones
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [DW-1:0]    hi_q, hi_d;
    logic [DW-1:0]    lo_q, lo_d;

    logic [DW:0]      rem_shift_s;
    logic             ge_s;
    logic [DW-1:0]    rem_sub_s;
    logic [DW-1:0]    rem_next_s;
    logic [DW-1:0]    quo_next_s;
    logic             fast_zero_s;
    logic             last_s;

    // One restoring step: shift in the next dividend bit, then subtract if it fits.
    always_comb begin
        rem_shift_s = {rem_q, dvd_q[DW-1]};
        ge_s        = (rem_shift_s >= {1'b0, dvs_q});
        rem_sub_s   = rem_shift_s[DW-1:0] - dvs_q;
        if (ge_s) begin
            rem_next_s = rem_sub_s;
        end else begin
            rem_next_s = rem_shift_s[DW-1:0];
        end
        quo_next_s = {quo_q[DW-2:0], ge_s};
        last_s     = (cnt_q == CNT_W'(DW - 1));
`ifdef DIV_ZERO_FAST_EN
        fast_zero_s = (b == {DW{1'b0}});
`else
        fast_zero_s = 1'b0;
`endif
    end

    // Next-state, datapath load/iterate and result write-back.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        dvd_d     = dvd_q;
        dvs_d     = dvs_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        bzero_d   = bzero_q;
        busy_d    = busy_q;
        done_d    = 1'b0;
        hi_d      = hi_q;
        lo_d      = lo_q;

        if (flush) begin
            // Cancel wins over everything. Any issuing start is dropped and hi/lo are left untouched.
            state_d = ST_IDLE;
            busy_d  = 1'b0;
            cnt_d   = {CNT_W{1'b0}};
        end else begin
            case (state_q)
                ST_IDLE: begin
                    busy_d = 1'b0;
                    if (start) begin
                        if (fast_zero_s) begin
                            lo_d   = {DW{1'b1}};
                            hi_d   = a;
                            done_d = 1'b1;
                        end else begin
                            dvd_d     = abs2c(a, mdsign);
                            dvs_d     = abs2c(b, mdsign);
                            neg_quo_d = mdsign & (a[DW-1] ^ b[DW-1]);
                            neg_rem_d = mdsign & a[DW-1];
                            bzero_d   = (b == {DW{1'b0}});
                            rem_d     = {DW{1'b0}};
                            quo_d     = {DW{1'b0}};
                            cnt_d     = {CNT_W{1'b0}};
                            busy_d    = 1'b1;
                            state_d   = ST_RUN;
                        end
                    end else begin
                        state_d = ST_IDLE;
                    end
                end
                ST_RUN: begin
                    rem_d = rem_next_s;
                    quo_d = quo_next_s;
                    dvd_d = {dvd_q[DW-2:0], 1'b0};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_s) begin
                        // With a zero divisor the remainder is |a|. Re-signing it gives back the raw a.
                        if (bzero_q) begin
                            lo_d = {DW{1'b1}};
                        end else if (neg_quo_q) begin
                            lo_d = neg2c(quo_next_s);
                        end else begin
                            lo_d = quo_next_s;
                        end
                        if (neg_rem_q) begin
                            hi_d = neg2c(rem_next_s);
                        end else begin
                            hi_d = rem_next_s;
                        end
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = ST_IDLE;
                    end else begin
                        busy_d = 1'b1;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    // State and datapath registers, asynchronously cleared.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= ST_IDLE;
            cnt_q     <= {CNT_W{1'b0}};
            dvd_q     <= {DW{1'b0}};
            dvs_q     <= {DW{1'b0}};
            rem_q     <= {DW{1'b0}};
            quo_q     <= {DW{1'b0}};
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            bzero_q   <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            hi_q      <= {DW{1'b0}};
            lo_q      <= {DW{1'b0}};
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dvd_q     <= dvd_d;
            dvs_q     <= dvs_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            bzero_q   <= bzero_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign hi   = hi_q;
    assign lo   = lo_q;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit. Expected {lo,hi} pairs are queued at issue.
// A negedge monitor pops and compares them on every done pulse.
module tb_div_unit;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        start = 1'b0;
    logic        mdsign = 1'b0;
    logic        flush = 1'b0;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        busy, done;
    logic [31:0] hi, lo;

    int checks = 0;
    int errors = 0;
    logic [63:0] exp_q[$];
    logic [63:0] mon_e;

    div_unit #(.DW(32), .CNT_W(6)) dut (
        .clk(clk), .resetn(resetn), .start(start), .mdsign(mdsign),
        .a(a), .b(b), .flush(flush),
        .busy(busy), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    // Reference: MIPS semantics from plain 64-bit arithmetic (truncating division).
    function automatic logic [63:0] ref_div(input bit sgn, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy;
        logic [63:0] q, r;
        if (y == 32'd0) return {32'hFFFF_FFFF, x};
        if (sgn) begin
            sx = longint'($signed(x));
            sy = longint'($signed(y));
            q = sx / sy;
            r = sx % sy;
        end else begin
            q = {32'd0, x} / {32'd0, y};
            r = {32'd0, x} % {32'd0, y};
        end
        return {q[31:0], r[31:0]};
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, expv);
        end
    endtask

    // Monitor: every done pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_done: lo %h hi %h with nothing outstanding", lo, hi);
            end else begin
                mon_e = exp_q.pop_front();
                check("lo", lo, mon_e[63:32]);
                check("hi", hi, mon_e[31:0]);
                check("busy_at_done", {31'd0, busy}, 32'd0);
            end
        end
    end

    // Presents an op for one edge (E0). Called just after a posedge and returns at E0+#1.
    task automatic start_op(input bit sgn, input logic [31:0] x, input logic [31:0] y, input bit push);
        mdsign = sgn;
        a = x;
        b = y;
        start = 1'b1;
        if (push) exp_q.push_back(ref_div(sgn, x, y));
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Waits for done, bounded. Checks the latency and the number of busy cycles.
    task automatic wait_done(input int exp_lat, input string name);
        int lat;
        int bcnt;
        lat = -1;
        bcnt = 0;
        for (int i = 0; i <= 60; i++) begin
            if (i > 0) begin
                @(posedge clk);
                #1;
            end
            if (done === 1'b1) begin
                lat = i;
                break;
            end
            if (busy === 1'b1) bcnt++;
        end
        check({name, "_latency"}, lat, exp_lat);
        check({name, "_busy_cycles"}, bcnt, exp_lat);
    endtask

    function automatic int lat_for(input logic [31:0] y);
`ifdef DIV_ZERO_FAST_EN
        if (y == 32'd0) return 0;
`endif
        return 32;
    endfunction

    task automatic run_op(input bit sgn, input logic [31:0] x, input logic [31:0] y, input string name);
        start_op(sgn, x, y, 1'b1);
        wait_done(lat_for(y), name);
    endtask

    initial begin
        int k;
        logic [31:0] ra, rb;
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_hi", hi, 32'd0);
        check("rst_lo", lo, 32'd0);
        resetn = 1'b1;
        @(posedge clk);
        #1;

        // Directed cases. Each one issues in the done cycle of the one before it.
        run_op(1'b0, 32'd100, 32'd7, "divu_100_7");
        run_op(1'b1, 32'hFFFF_FFF9, 32'd2, "div_m7_2");
        run_op(1'b0, 32'hFFFF_FFF9, 32'd2, "divu_m7_2");
        run_op(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, "div_min_m1");
        run_op(1'b1, 32'd9, 32'd3, "div_9_3_b2b");

        // A start pulsed while RUN is ignored. The result and completion time stay those of the original op.
        @(posedge clk);
        #1;
        start_op(1'b0, 32'd200, 32'd9, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        a = 32'd77;
        b = 32'd1;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(26, "start_in_run");

        // A flush in mid-run: busy drops, no done appears, and hi/lo keep the previous result.
        run_op(1'b0, 32'd50, 32'd5, "divu_50_5");
        @(posedge clk);
        #1;
        start_op(1'b0, 32'd1, 32'd1, 1'b0);
        repeat (9) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk);
        #1;
        flush = 1'b0;
        check("flush_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;
        check("flush_lo_held", lo, 32'd10);
        check("flush_hi_held", hi, 32'd0);

        // A flush and a start in the same cycle: the start is dropped.
        start = 1'b1;
        flush = 1'b1;
        a = 32'd3;
        b = 32'd1;
        @(posedge clk);
        #1;
        start = 1'b0;
        flush = 1'b0;
        check("flush_start_busy", {31'd0, busy}, 32'd0);
        repeat (40) @(posedge clk);
        #1;

        // Divide by zero.
        run_op(1'b1, 32'd5, 32'd0, "div_5_0");
        run_op(1'b1, 32'hFFFF_FFF0, 32'd0, "div_neg_0");

        // Asynchronous reset in mid-run clears the outputs at once.
        @(posedge clk);
        #1;
        start_op(1'b0, 32'd1000, 32'd3, 1'b0);
        repeat (4) @(posedge clk);
        #2;
        resetn = 1'b0;
        #1;
        check("arst_busy", {31'd0, busy}, 32'd0);
        check("arst_done", {31'd0, done}, 32'd0);
        check("arst_hi", hi, 32'd0);
        check("arst_lo", lo, 32'd0);
        @(posedge clk);
        #1;
        resetn = 1'b1;
        @(posedge clk);
        #1;
        run_op(1'b0, 32'd8, 32'd3, "divu_8_3");

        // Random ops, biased toward the corner divisors and the most negative dividend.
        for (int n = 0; n < 40; n++) begin
            k = $urandom_range(0, 7);
            ra = $urandom;
            if ($urandom_range(0, 5) == 0) ra = 32'h8000_0000;
            case (k)
                0: rb = 32'd0;
                1: rb = 32'd1;
                2: rb = 32'hFFFF_FFFF;
                3: rb = $urandom_range(1, 15);
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk);
                #1;
            end
            run_op(1'($urandom_range(0, 1)), ra, rb, "rand");
        end

        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL outstanding: %0d results never completed, expected 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
